// File: rtl/axis_fir_decimator.sv
// AXI-Stream decimator with round-half-up requantization, saturation and a 2-entry output buffer.
// Optional saturation event counter on port sat_count is enabled by defining SAT_COUNT_EN.
module axis_fir_decimator #(
    parameter int DATA_IN_WIDTH  = 19,
    parameter int DATA_OUT_WIDTH = 8,
    parameter int SHIFT          = 3,
    parameter int DECIM          = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_OUT_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready
`ifdef SAT_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      sat_count
`endif
);

    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [DATA_IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((DATA_IN_WIDTH + 1)'(1) << RND_SH) : '0;
    localparam logic signed [DATA_IN_WIDTH:0] SAT_MAX =
        (DATA_IN_WIDTH + 1)'((1 << (DATA_OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    if (DECIM < 1 || CNT_WIDTH < 1 || DATA_OUT_WIDTH > DATA_IN_WIDTH) begin : g_param_check
        $error("axis_fir_decimator: unsupported parameter combination");
    end

    logic [PH_W-1:0]           phase;
    logic [1:0]                count;
    logic                      rd_ptr;
    logic                      wr_ptr;
    logic [DATA_OUT_WIDTH-1:0] buf_data [2];
    logic                      buf_last [2];
    logic                      s_hs;
    logic                      keep;
    logic                      push;
    logic                      pop;
    logic signed [DATA_IN_WIDTH:0] rounded;
    logic signed [DATA_IN_WIDTH:0] shifted;
    logic [DATA_OUT_WIDTH-1:0] q_data;

    // Ready looks only at registered occupancy, never at m_axis_tready.
    assign s_axis_tready = rst_n && (count != 2'd2);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign keep          = (phase == '0) || s_axis_tlast;
    assign push          = s_hs && keep;
    assign m_axis_tvalid = (count != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tlast  = buf_last[rd_ptr];

    always_comb begin
        rounded = $signed({s_axis_tdata[DATA_IN_WIDTH-1], s_axis_tdata}) + RND;
        shifted = rounded >>> SHIFT;
        q_data  = shifted[DATA_OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            q_data = SAT_MAX[DATA_OUT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            q_data = SAT_MIN[DATA_OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= '0;
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            if (s_hs) begin
                phase <= (s_axis_tlast || phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
            if (push) begin
                buf_data[wr_ptr] <= q_data;
                buf_last[wr_ptr] <= s_axis_tlast;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef SAT_COUNT_EN
    logic clip;
    assign clip = (shifted > SAT_MAX) || (shifted < SAT_MIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (push && clip && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/axis_fir_decimator.md
# axis_fir_decimator

Downstream companion of the AXI-Stream FIR filter. It consumes the wide signed FIR output stream, keeps every DECIM-th sample, and requantizes each kept sample to DATA_OUT_WIDTH bits with a rounding right shift and saturation. Results leave through a 2-entry output buffer with full AXI-Stream backpressure. Frame boundaries (tlast) are preserved and the last sample of every frame is always emitted.

## Interface
- DATA_IN_WIDTH, 19: input sample width; matches FIR output width (3+8+8).
- DATA_OUT_WIDTH, 8: output sample width.
- SHIFT, 3: arithmetic right shift applied before saturation. 0 means no shift and no rounding.
- DECIM, 2: decimation factor, ≥1. 1 means pass every sample.
- CNT_WIDTH, 16: width of sat_count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_IN_WIDTH  signed input sample
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  last sample of input frame
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_OUT_WIDTH  signed output sample
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  last sample of output frame
- m_axis_tready  in  1  downstream ready
- sat_count  out  CNT_WIDTH  saturation event count (only with SAT_COUNT_EN)

## Operation
- Input handshake: s_axis_tvalid && s_axis_tready.
- Phase counter 0..DECIM-1.
  - Advances by 1 on every input handshake and wraps DECIM-1 → 0.
  - A handshake with s_axis_tlast=1 forces phase to 0, so the next frame starts aligned.
- A sample is kept if phase==0 or s_axis_tlast=1. All other handshaked samples are consumed and dropped.
- Arithmetic on a kept sample x:
  - r = x + 2^(SHIFT-1), computed at DATA_IN_WIDTH+1 bits so it cannot overflow (no add when SHIFT=0).
  - y = r >>> SHIFT (arithmetic shift, i.e. round half toward +inf).
  - Saturate y to [-2^(DATA_OUT_WIDTH-1), 2^(DATA_OUT_WIDTH-1)-1].
- Output buffer: 2-entry FIFO of {data, last}, with occupancy count 0..2.
  - A kept sample pushes one entry, with last = the s_axis_tlast of that handshake.
  - The head entry drives m_axis_*. Pop occurs on m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle leave count unchanged.
- Ready and valid:
  - s_axis_tready = rst_n && (count != 2). It depends only on registered state, with no combinational path from m_axis_tready.
  - m_axis_tvalid = (count != 0).
- Dropped samples are accepted whenever s_axis_tready=1 and never occupy the buffer.

## Timing
- Reset (rst_n low at a clk edge): count=0, phase=0, buffer data/last cleared, sat_count=0.
  - Effective from the next cycle: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0 while rst_n is low, and 1 from the first cycle after reset releases.
- Latency: a kept sample handshaked at edge N appears on m_axis_* in cycle N+1 if the buffer was empty.
- Throughput: one input per cycle while m_axis_tready=1; output rate is 1/DECIM of input rate.
- Full: at count==2, s_axis_tready=0. The dropped/kept decision is not evaluated and no input is consumed.
- Reset mid-frame discards all buffered entries and the phase. The next accepted sample is phase 0.
- tlast on a phase-0 sample produces exactly one output with last=1 (no duplicate).
- m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.

## Configuration
- SAT_COUNT_EN defined:
  - sat_count is present.
  - It increments by 1 on each kept sample whose value was clipped.
  - It holds at all-ones, clears on reset, and is registered, updating at the push edge.
- SAT_COUNT_EN undefined: sat_count port and counter are absent. Datapath behaviour is identical.

## Test plan
Defaults: DECIM=2, SHIFT=3, DATA_OUT_WIDTH=8, m_axis_tready=1 unless stated.
- Decimate and round: inputs 8, 100, -12, 7, no tlast → outputs 1, -1 ((8+4)>>3, (-12+4)>>>3). Each output appears one cycle after its input handshake.
- Saturation: kept inputs 2000 and -2000 → outputs 127 and -128. With SAT_COUNT_EN, sat_count=2; input 1000 afterwards → 125, sat_count stays 2.
- tlast on odd phase: frame 8, 16, 24, 32 with tlast on 32 → outputs 1, 3, 4(last=1). Next frame input 40 is kept → output 5, last=0.
- Backpressure: m_axis_tready=0, kept inputs 8, 24, 40 offered back-to-back (every other sample).
  - s_axis_tready drops the cycle after the second kept push; 40 and its preceding dropped sample wait.
  - After m_axis_tready=1 → outputs 1, 3, 5 in order, no loss or duplication.
- Reset mid-operation: fill buffer (count=2), pulse rst_n low one cycle → next cycle m_axis_tvalid=0, s_axis_tready=0, sat_count=0.
  - After release, first input 16 is kept → output 2.
